// File: rtl/req_ready_seq_pkg.sv
// Shared definitions for the req_ready_seq request sequencer: state
// encoding, default timing constants and a width helper.
package req_ready_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } req_seq_state_e;

  localparam int REQ_SEQ_TIMEOUT   = 16;
  localparam int REQ_SEQ_GAP       = 2;
  localparam int REQ_SEQ_MAX_RETRY = 2;

  // Width of a counter holding 0..max_retry, never narrower than one bit.
  function automatic int req_seq_rw(input int max_retry);
    int w;
    w = $clog2(max_retry + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/req_ready_seq_if.sv
// Handshake bundle between a CPU sub-unit, the request sequencer and the
// responder's ready generator. With REQ_READY_SEQ_STATS_EN defined the
// bundle also carries the latency/error statistics outputs.
interface req_ready_seq_if import req_ready_seq_pkg::*; #(
  parameter int LW = $clog2(REQ_SEQ_TIMEOUT + 1),
  parameter int RW = req_seq_rw(REQ_SEQ_MAX_RETRY)
);
  logic          ce_i;
  logic          start_i;
  logic          abort_i;
  logic          rdy_i;
  logic          req_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [LW-1:0] lat_o;
  logic [RW-1:0] retries_o;
`ifdef REQ_READY_SEQ_STATS_EN
  logic [LW-1:0] max_lat_o;
  logic [15:0]   err_cnt_o;

  modport master (
    input  ce_i, start_i, abort_i, rdy_i,
    output req_o, busy_o, done_o, err_o, lat_o, retries_o, max_lat_o, err_cnt_o
  );
  modport slave (
    output ce_i, start_i, abort_i, rdy_i,
    input  req_o, busy_o, done_o, err_o, lat_o, retries_o, max_lat_o, err_cnt_o
  );
`else
  modport master (
    input  ce_i, start_i, abort_i, rdy_i,
    output req_o, busy_o, done_o, err_o, lat_o, retries_o
  );
  modport slave (
    output ce_i, start_i, abort_i, rdy_i,
    input  req_o, busy_o, done_o, err_o, lat_o, retries_o
  );
`endif
endinterface

// File: rtl/req_ready_seq_timer.sv
// req_seq_timer: clearable up-counter with clock enable and a terminal-count
// flag. Used for both the per-attempt request counter and the gap counter.
module req_seq_timer #(
  parameter int W    = 5,
  parameter int TERM = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ce_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_r;

  // Count up while enabled; clear takes priority so an attempt starts at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= {W{1'b0}};
    end else if (ce_i) begin
      if (clr_i) begin
        cnt_r <= {W{1'b0}};
      end else if (inc_i) begin
        cnt_r <= cnt_r + W'(1);
      end
    end
  end

  assign cnt_o = cnt_r;
  assign tc_o  = (cnt_r == W'(TERM));

endmodule

// File: rtl/req_ready_seq.sv
// req_ready_seq: initiator-side request sequencer. Raises a level request,
// holds it until ready, measures latency, times out a stalled responder and
// retries after a request-low gap. Define REQ_READY_SEQ_STATS_EN to add the
// max-latency and error-count statistics outputs.
module req_ready_seq import req_ready_seq_pkg::*; #(
  parameter int TIMEOUT    = REQ_SEQ_TIMEOUT,
  parameter int MAX_RETRY  = REQ_SEQ_MAX_RETRY,
  parameter int GAP_CYCLES = REQ_SEQ_GAP,
  parameter int LW         = $clog2(TIMEOUT + 1),
  parameter int RW         = req_seq_rw(MAX_RETRY)
) (
  input logic            clk_i,
  input logic            rst_i,
  req_ready_seq_if.master bus
);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_GAP  = GAP;

  logic          ce_s, start_s, abort_s, rdy_s;
  logic [1:0]    state_r, state_nxt_s;
  logic          req_r, busy_r, done_r, err_r;
  logic [LW-1:0] lat_r, lat_nxt_s;
  logic [RW-1:0] retries_r, ret_nxt_s;
  logic [RW-1:0] retry_r, retry_nxt_s;
  logic          done_nxt_s, err_nxt_s;
  logic [LW-1:0] cnt_s;
  logic          cnt_tc_s;
  logic [GW-1:0] gap_cnt_unused_s;
  logic          gap_tc_s;
  logic          in_req_s, in_gap_s;

  assign ce_s     = bus.ce_i;
  assign start_s  = bus.start_i;
  assign abort_s  = bus.abort_i;
  assign rdy_s    = bus.rdy_i;
  assign in_req_s = (state_r == S_REQ);
  assign in_gap_s = (state_r == S_GAP);

  // Each counter sits at zero outside its own state, so entry always starts fresh.
  req_seq_timer #(.W(LW), .TERM(TIMEOUT - 1)) u_att_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ce_i  (ce_s),
    .clr_i (!in_req_s),
    .inc_i (in_req_s),
    .cnt_o (cnt_s),
    .tc_o  (cnt_tc_s)
  );

  req_seq_timer #(.W(GW), .TERM(GAP_CYCLES - 1)) u_gap_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ce_i  (ce_s),
    .clr_i (!in_gap_s),
    .inc_i (in_gap_s),
    .cnt_o (gap_cnt_unused_s),
    .tc_o  (gap_tc_s)
  );

  // Next-state and result decode; abort beats ready, ready beats timeout.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    lat_nxt_s   = lat_r;
    ret_nxt_s   = retries_r;
    retry_nxt_s = retry_r;
    case (state_r)
      S_IDLE: begin
        if (start_s && !abort_s) begin
          state_nxt_s = S_REQ;
          retry_nxt_s = {RW{1'b0}};
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (abort_s) begin
          state_nxt_s = S_IDLE;
        end else if (rdy_s) begin
          state_nxt_s = S_IDLE;
          done_nxt_s  = 1'b1;
          lat_nxt_s   = cnt_s + LW'(1);
          ret_nxt_s   = retry_r;
        end else if (cnt_tc_s) begin
          if (retry_r < RW'(MAX_RETRY)) begin
            state_nxt_s = S_GAP;
            retry_nxt_s = retry_r + RW'(1);
          end else begin
            state_nxt_s = S_IDLE;
            err_nxt_s   = 1'b1;
            ret_nxt_s   = retry_r;
          end
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_GAP: begin
        if (abort_s) begin
          state_nxt_s = S_IDLE;
        end else if (gap_tc_s) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_GAP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; everything holds while ce is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= S_IDLE;
      req_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      lat_r     <= {LW{1'b0}};
      retries_r <= {RW{1'b0}};
      retry_r   <= {RW{1'b0}};
    end else if (ce_s) begin
      state_r   <= state_nxt_s;
      req_r     <= (state_nxt_s == S_REQ);
      busy_r    <= (state_nxt_s != S_IDLE);
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      lat_r     <= lat_nxt_s;
      retries_r <= ret_nxt_s;
      retry_r   <= retry_nxt_s;
    end
  end

  assign bus.req_o     = req_r;
  assign bus.busy_o    = busy_r;
  assign bus.done_o    = done_r;
  assign bus.err_o     = err_r;
  assign bus.lat_o     = lat_r;
  assign bus.retries_o = retries_r;

`ifdef REQ_READY_SEQ_STATS_EN
  logic [LW-1:0] max_lat_r;
  logic [15:0]   err_cnt_r;

  // Track the worst successful latency and count failures (saturating).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_lat_r <= {LW{1'b0}};
      err_cnt_r <= 16'd0;
    end else if (ce_s) begin
      if (done_nxt_s && (lat_nxt_s > max_lat_r)) begin
        max_lat_r <= lat_nxt_s;
      end
      if (err_nxt_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
    end
  end

  assign bus.max_lat_o = max_lat_r;
  assign bus.err_cnt_o = err_cnt_r;
`endif

endmodule

// File: tb/tb_req_ready_seq.sv
// Self-checking bench for req_ready_seq: directed vector table, hand-written
// multi-cycle scenarios with a 4-deep ready generator, then random stimulus
// against a transaction-level reference model.
module tb_req_ready_seq;
  localparam int TIMEOUT    = 16;
  localparam int MAX_RETRY  = 2;
  localparam int GAP_CYCLES = 2;
  localparam int LW         = 5;
  localparam int RW         = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  req_ready_seq_if #(.LW(LW), .RW(RW)) bus();

  req_ready_seq #(
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .GAP_CYCLES(GAP_CYCLES),
    .LW(LW), .RW(RW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Responder: ready rises four ce cycles after request, clears when request drops.
  logic       use_resp, resp_en, rdy_man;
  logic [3:0] resp_sr;
  assign bus.rdy_i = use_resp ? (resp_sr[3] & resp_en) : rdy_man;

  always @(posedge clk or posedge rst) begin
    if (rst) resp_sr <= 4'd0;
    else if (bus.ce_i) resp_sr <= bus.req_o ? {resp_sr[2:0], 1'b1} : 4'd0;
  end

  typedef struct {
    logic ce, st, ab, rd;
    logic rq, bz, dn, er;
    logic [LW-1:0] lat;
    logic [RW-1:0] ret;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mkv(input logic ce, input logic st, input logic ab, input logic rd,
                               input logic rq, input logic bz, input logic dn, input logic er,
                               input int lat, input int ret);
    vec_t v;
    v.ce = ce; v.st = st; v.ab = ab; v.rd = rd;
    v.rq = rq; v.bz = bz; v.dn = dn; v.er = er;
    v.lat = LW'(lat); v.ret = RW'(ret);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic ce, input logic st, input logic ab, input logic rd);
    bus.ce_i = ce; bus.start_i = st; bus.abort_i = ab; rdy_man = rd;
  endtask

  function automatic logic [31:0] out_pack();
    return {21'd0, bus.req_o, bus.busy_o, bus.done_o, bus.err_o, bus.lat_o, bus.retries_o};
  endfunction

  // Reference model: transaction view with age counters and a countdown gap.
  logic m_active, m_in_gap, m_done, m_err;
  int   m_age, m_gap_left, m_attempt, m_lat, m_ret, m_max_lat, m_err_cnt;

  task automatic model_reset();
    m_active = 1'b0; m_in_gap = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_age = 0; m_gap_left = 0; m_attempt = 0; m_lat = 0; m_ret = 0;
    m_max_lat = 0; m_err_cnt = 0;
  endtask

  task automatic model_step(input logic st, input logic ab, input logic rd);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!m_active) begin
      if (st && !ab) begin
        m_active = 1'b1; m_in_gap = 1'b0; m_age = 0; m_attempt = 1;
      end
    end else if (ab) begin
      m_active = 1'b0;
    end else if (m_in_gap) begin
      m_gap_left--;
      if (m_gap_left == 0) begin
        m_in_gap = 1'b0; m_age = 0;
      end
    end else begin
      m_age++;
      if (rd) begin
        m_done = 1'b1; m_lat = m_age; m_ret = m_attempt - 1; m_active = 1'b0;
        if (m_age > m_max_lat) m_max_lat = m_age;
      end else if (m_age == TIMEOUT) begin
        if (m_attempt == MAX_RETRY + 1) begin
          m_err = 1'b1; m_ret = m_attempt - 1; m_active = 1'b0;
          if (m_err_cnt < 65535) m_err_cnt++;
        end else begin
          m_attempt++; m_in_gap = 1'b1; m_gap_left = GAP_CYCLES;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_pack();
    logic [LW-1:0] l;
    logic [RW-1:0] r;
    l = LW'(m_lat);
    r = RW'(m_ret);
    return {21'd0, (m_active && !m_in_gap), m_active, m_done, m_err, l, r};
  endfunction

  int n, k, mism, rdy_pct;
  logic exp_req, c_st, c_ab, c_rd, c_ce;

  initial begin
    rst = 1'b1;
    use_resp = 1'b0; resp_en = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", out_pack(), 32'd0);

    // ---------------- directed vector table ----------------
    vt[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    vt[1]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0); // start+abort in IDLE
    vt[2]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0); // rdy ignored in IDLE
    vt[3]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0); // start
    vt[4]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0); // ce low: hold
    vt[5]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0); // ready first cycle
    vt[6]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0); // done held
    vt[7]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    vt[8]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    vt[9]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    vt[10] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0); // start while busy
    vt[11] = mkv(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0); // abort beats rdy
    vt[12] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    vt[13] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0);
    vt[14] = mkv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0); // ready second cycle
    vt[15] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0); // abort in IDLE
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].ce, vt[i].st, vt[i].ab, vt[i].rd);
      tick();
      check($sformatf("vec%0d", i), out_pack(),
            {21'd0, vt[i].rq, vt[i].bz, vt[i].dn, vt[i].er, vt[i].lat, vt[i].ret});
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // ---------------- A: responder ready after 4 clocks ----------------
    use_resp = 1'b1; resp_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("a_req_rise", {31'd0, bus.req_o}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!bus.done_o && n < 100) begin tick(); n++; end
    check("a_done", {31'd0, bus.done_o}, 32'd1);
    check("a_done_cycle", n, 5);
    check("a_lat", {27'd0, bus.lat_o}, 32'd5);
    check("a_retries", {30'd0, bus.retries_o}, 32'd0);
    check("a_req_low_with_done", {31'd0, bus.req_o}, 32'd0);
    tick();
    check("a_done_pulse_end", {31'd0, bus.done_o}, 32'd0);
    repeat (3) tick();

    // ---------------- B: responder never ready ----------------
    resp_en = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    k = 0; mism = 0;
    while (!bus.err_o && k < 200) begin
      exp_req = ((k % (TIMEOUT + GAP_CYCLES)) < TIMEOUT);
      if (bus.req_o !== exp_req) mism++;
      tick(); k++;
    end
    check("b_len", k, 3 * TIMEOUT + 2 * GAP_CYCLES);
    check("b_req_pattern", mism, 0);
    check("b_err", {31'd0, bus.err_o}, 32'd1);
    check("b_retries", {30'd0, bus.retries_o}, 32'd2);
    check("b_busy", {31'd0, bus.busy_o}, 32'd0);
    check("b_lat_kept", {27'd0, bus.lat_o}, 32'd5);
    tick();
    check("b_err_pulse_end", {31'd0, bus.err_o}, 32'd0);
    repeat (3) tick();

    // ---------------- C: ready only on second attempt ----------------
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.req_o && n < 100) begin tick(); n++; end
    check("c_first_window", n, TIMEOUT);
    resp_en = 1'b1;
    n = 0;
    while (!bus.done_o && n < 100) begin tick(); n++; end
    check("c_done_cycle", n, GAP_CYCLES + 5);
    check("c_retries", {30'd0, bus.retries_o}, 32'd1);
    check("c_lat", {27'd0, bus.lat_o}, 32'd5);
    repeat (3) tick();

    // ---------------- D: abort in REQ cycle 3 with rdy high ----------------
    use_resp = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("d_abort", out_pack(), {21'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 2'd1});
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("d_start_ignored", {31'd0, bus.busy_o}, 32'd0);
    repeat (2) tick();

    // ---------------- E: ce toggling ----------------
    use_resp = 1'b1; resp_en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n = 0;
    while (!bus.done_o && n < 100) begin
      n++;
      drive((n % 2) == 0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("e_done_cycle", n, 10);
    check("e_lat", {27'd0, bus.lat_o}, 32'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("e_done_held", {31'd0, bus.done_o}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("e_done_cleared", {31'd0, bus.done_o}, 32'd0);
    repeat (2) tick();

    // ---------------- F: reset mid-REQ ----------------
`ifdef REQ_READY_SEQ_STATS_EN
    check("f_max_lat_before", {27'd0, bus.max_lat_o}, 32'd5);
    check("f_err_cnt_before", {16'd0, bus.err_cnt_o}, 32'd1);
`endif
    use_resp = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check("f_async_reset", out_pack(), 32'd0);
`ifdef REQ_READY_SEQ_STATS_EN
    check("f_max_lat_reset", {27'd0, bus.max_lat_o}, 32'd0);
    check("f_err_cnt_reset", {16'd0, bus.err_cnt_o}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // ---------------- random stimulus vs reference model ----------------
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      check("rand", out_pack(), model_pack());
`ifdef REQ_READY_SEQ_STATS_EN
      check("rand_max_lat", {27'd0, bus.max_lat_o}, 32'(m_max_lat));
      check("rand_err_cnt", {16'd0, bus.err_cnt_o}, 32'(m_err_cnt));
`endif
      case ((i / 250) % 4)
        0:       rdy_pct = 0;
        1:       rdy_pct = 3;
        2:       rdy_pct = 25;
        default: rdy_pct = 60;
      endcase
      c_ce = ($urandom_range(0, 3) != 0);
      c_st = ($urandom_range(0, 9) == 0);
      c_ab = ($urandom_range(0, 59) == 0);
      c_rd = ($urandom_range(0, 99) < rdy_pct);
      drive(c_ce, c_st, c_ab, c_rd);
      if (c_ce) model_step(c_st, c_ab, c_rd);
      tick();
    end
    check("rand_final", out_pack(), model_pack());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
